mem_access_responder: RTL and testbench
=======================================

// Module: mem_access_responder
// PURPOSE
//  Memory-side responder for the MAC port of the memory access interconnector.
//  Accepts read and write burst requests (Valid/Ready, Addr/Tag/Id/Len/QoS), executes them on a
//  single-port synchronous SRAM and returns read data bursts (ValidRsp/TagRsp/DataRsp/StatusRsp/EoD).
//  Serves one burst at a time; arbitrates between pending read and write requests.
// PARAMETERS
//  AW     10    SRAM word-address width
//  DEPTH  1024  implemented SRAM words (DEPTH <= 2**AW); word index >= DEPTH is out of range
// PORTS
//  clk          in   1   clock
//  reset        in   1   asynchronous, active-high reset
//  iValidRd     in   1   read request valid
//  iAddrRd      in   32  read byte address
//  iTagRd       in   4   read tag, echoed on oTagRsp
//  iIdRd        in   3   read source id (accepted, unused)
//  iLenRd       in   2   read beats minus 1 (1..4 beats)
//  iQoSRd       in   4   read priority
//  oReadyRd     out  1   read request accepted
//  oValidRsp    out  1   read response beat valid
//  oTagRsp      out  4   tag of current response burst
//  oDataRsp     out  32  read data
//  oStatusRsp   out  2   00 OK, 01 out of range, 11 misaligned
//  oEoD         out  1   last beat of response burst
//  iReadyRsp    in   1   response beat accepted
//  iValidWr     in   1   write header+first beat valid (in IDLE); data beat valid (in WR)
//  iAddrWr      in   32  write byte address
//  iTagWr/iIdWr/iLenWr/iQoSWr  in  4/3/2/4  as read side
//  oReadyWr     out  1   write header/data beat accepted
//  iDataWr      in   32  write data
//  iMaskWr      in   4   byte enables
//  iEoD         in   1   last write data beat
//  oMemCs       out  1   SRAM select
//  oMemWe       out  1   SRAM write enable
//  oMemAddr     out  AW  SRAM word address
//  oMemWdata    out  32  SRAM write data
//  oMemBe       out  4   SRAM byte enables
//  iMemRdata    in   32  SRAM read data, valid the cycle after oMemCs&~oMemWe
// BEHAVIOUR
//  - Reset (async): state IDLE, every output 0, pending burst discarded, no SRAM access after reset.
//  - FSM: IDLE, WR, RD_ISSUE, RD_CAP, RD_RSP.
//  - IDLE: oReadyRd/oReadyWr combinational = granted side's valid. Only one is high per cycle; both 0 while reset.
//  - Arbitration when both valid: higher QoS wins; tie -> the side not granted last (initially write).
//  - Handshake captures Addr, Tag, Len; beat count = Len+1; word address = Addr[AW+1:2], +1 per beat, no wrap.
//  - Misaligned (Addr[1:0]!=0): whole burst gets status 11; writes never touch SRAM; reads return data 0.
//  - Beat with word index >= DEPTH: status 01; write beat dropped; read data 0. Other beats unaffected.
//  - Write: header cycle carries beat 0. WR keeps oReadyWr=1. Each accepted beat -> registered SRAM write
//    (oMemCs=oMemWe=1, oMemBe=iMaskWr) the next cycle. Burst ends on iEoD or after Len+1 beats, whichever first.
//    Then back to IDLE. No write response.
//  - Read: RD_ISSUE drives oMemCs=1,oMemWe=0; RD_CAP registers iMemRdata; RD_RSP holds oValidRsp=1 and stable
//    data/tag/status until iReadyRsp. oEoD=1 on beat Len. Handshake -> RD_ISSUE (more beats) or IDLE.
//    Latency: request handshake cycle T -> oValidRsp at T+3; 3 cycles/beat minimum.
//  - Out-of-range/misaligned read beats still take RD_ISSUE/RD_CAP timing, with oMemCs=0.
//  - oMemCs=0 in every other state; oMemAddr/oMemWdata/oMemBe don't-care when oMemCs=0.
// CONFIGURATION
//  MEM_RSP_QOS_ARB_EN defined: QoS-based arbitration as above.
//  Not defined: iQoS* ignored; strict alternation on contention (initially write).
// TESTING
//  1 write Addr=0x10,Len=3, data A0..A3, mask F -> 4 SRAM writes to words 4..7; read back tag 5 -> 4 beats, EoD on 4th, status 00
//  2 read Len=1 with iReadyRsp=0 for 5 cycles -> oValidRsp/oDataRsp held stable; beat 2 only after accept
//  3 write Len=3 with iEoD on beat 1 -> exactly 2 SRAM writes, FSM IDLE next cycle
//  4 read Addr=(DEPTH-1)*4,Len=1 -> beat0 status 00 real data, beat1 status 01 data 0; Addr=0x2 -> status 11, no write
//  5 simultaneous Rd QoS 2 / Wr QoS 9 -> write first (macro on); tie -> alternates; macro off -> alternates regardless
//  6 assert reset mid read burst -> outputs 0 same cycle; after release IDLE, no stale oValidRsp

Source files
------------

// File: rtl/mem_access_responder_if.sv
// Request/response and SRAM signal bundle for mem_access_responder.
// AW must match the AW of the responder it is bound to.
interface mem_access_responder_if #(
  parameter int AW = 10
);
  logic          iValidRd;
  logic [31:0]   iAddrRd;
  logic [3:0]    iTagRd;
  logic [2:0]    iIdRd;
  logic [1:0]    iLenRd;
  logic [3:0]    iQoSRd;
  logic          oReadyRd;
  logic          oValidRsp;
  logic [3:0]    oTagRsp;
  logic [31:0]   oDataRsp;
  logic [1:0]    oStatusRsp;
  logic          oEoD;
  logic          iReadyRsp;
  logic          iValidWr;
  logic [31:0]   iAddrWr;
  logic [3:0]    iTagWr;
  logic [2:0]    iIdWr;
  logic [1:0]    iLenWr;
  logic [3:0]    iQoSWr;
  logic          oReadyWr;
  logic [31:0]   iDataWr;
  logic [3:0]    iMaskWr;
  logic          iEoD;
  logic          oMemCs;
  logic          oMemWe;
  logic [AW-1:0] oMemAddr;
  logic [31:0]   oMemWdata;
  logic [3:0]    oMemBe;
  logic [31:0]   iMemRdata;

  modport slave (
    input  iValidRd, iAddrRd, iTagRd, iIdRd, iLenRd, iQoSRd, iReadyRsp,
    input  iValidWr, iAddrWr, iTagWr, iIdWr, iLenWr, iQoSWr, iDataWr, iMaskWr, iEoD,
    input  iMemRdata,
    output oReadyRd, oValidRsp, oTagRsp, oDataRsp, oStatusRsp, oEoD, oReadyWr,
    output oMemCs, oMemWe, oMemAddr, oMemWdata, oMemBe
  );

  modport master (
    output iValidRd, iAddrRd, iTagRd, iIdRd, iLenRd, iQoSRd, iReadyRsp,
    output iValidWr, iAddrWr, iTagWr, iIdWr, iLenWr, iQoSWr, iDataWr, iMaskWr, iEoD,
    output iMemRdata,
    input  oReadyRd, oValidRsp, oTagRsp, oDataRsp, oStatusRsp, oEoD, oReadyWr,
    input  oMemCs, oMemWe, oMemAddr, oMemWdata, oMemBe
  );
endinterface

// File: rtl/mem_access_responder.sv
// Single-burst read/write responder in front of a single-port synchronous SRAM.
// Define MEM_RSP_QOS_ARB_EN for QoS arbitration; otherwise contention strictly alternates.
module mem_access_responder #(
  parameter int AW    = 10,
  parameter int DEPTH = 1024
) (
  input  logic clk,
  input  logic reset,
  mem_access_responder_if.slave bus
);
  typedef enum logic [2:0] {IDLE, WR, RD_ISSUE, RD_CAP, RD_RSP} state_e;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_W   = (AW+1)'(1);

  state_e        state_q, state_d;
  logic [AW:0]   word_q, word_d;
  logic [1:0]    beat_q, beat_d;
  logic [1:0]    len_q, len_d;
  logic [1:0]    status_q, status_d;
  logic [3:0]    tag_q, tag_d;
  logic          misal_q, misal_d;
  logic          last_rd_q, last_rd_d;
  logic [31:0]   data_q, data_d;
  logic          wr_cs_q, wr_cs_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;

  logic          wr_wins, gnt_wr, gnt_rd, beat_ok, beat_last;
  logic [AW:0]   wr_word, rd_word;
  logic          unused_ok;

  assign wr_word   = {1'b0, bus.iAddrWr[AW+1:2]};
  assign rd_word   = {1'b0, bus.iAddrRd[AW+1:2]};
  assign beat_ok   = !misal_q && (word_q < DEPTH_W);
  assign beat_last = (beat_q == len_q);
  assign unused_ok = ^{bus.iIdRd, bus.iIdWr, bus.iTagWr, bus.iQoSRd, bus.iQoSWr,
                       bus.iAddrRd[31:AW+2], bus.iAddrWr[31:AW+2]};

  // last_rd_q starts at 1 so the first tie goes to the write side
`ifdef MEM_RSP_QOS_ARB_EN
  always_comb begin
    if (bus.iQoSWr != bus.iQoSRd) wr_wins = (bus.iQoSWr > bus.iQoSRd);
    else                          wr_wins = last_rd_q;
  end
`else
  assign wr_wins = last_rd_q;
`endif

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    beat_d    = beat_q;
    len_d     = len_q;
    status_d  = status_q;
    tag_d     = tag_q;
    misal_d   = misal_q;
    last_rd_d = last_rd_q;
    data_d    = data_q;
    wr_cs_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    gnt_wr    = 1'b0;
    gnt_rd    = 1'b0;
    unique case (state_q)
      IDLE: begin
        gnt_wr = bus.iValidWr && (!bus.iValidRd || wr_wins);
        gnt_rd = bus.iValidRd && !gnt_wr;
        if (gnt_wr) begin
          last_rd_d = 1'b0;
          len_d     = bus.iLenWr;
          misal_d   = |bus.iAddrWr[1:0];
          wr_cs_d   = !(|bus.iAddrWr[1:0]) && (wr_word < DEPTH_W);
          wr_addr_d = wr_word[AW-1:0];
          wdata_d   = bus.iDataWr;
          be_d      = bus.iMaskWr;
          word_d    = wr_word + ONE_W;
          beat_d    = 2'd1;
          if (!bus.iEoD && (bus.iLenWr != 2'd0)) state_d = WR;
        end else if (gnt_rd) begin
          last_rd_d = 1'b1;
          len_d     = bus.iLenRd;
          tag_d     = bus.iTagRd;
          misal_d   = |bus.iAddrRd[1:0];
          word_d    = rd_word;
          beat_d    = 2'd0;
          state_d   = RD_ISSUE;
        end
      end
      WR: begin
        if (bus.iValidWr) begin
          wr_cs_d   = beat_ok;
          wr_addr_d = word_q[AW-1:0];
          wdata_d   = bus.iDataWr;
          be_d      = bus.iMaskWr;
          word_d    = word_q + ONE_W;
          beat_d    = beat_q + 2'd1;
          if (bus.iEoD || beat_last) state_d = IDLE;
        end
      end
      RD_ISSUE: state_d = RD_CAP;
      RD_CAP: begin
        data_d   = beat_ok ? bus.iMemRdata : 32'h0;
        status_d = misal_q ? 2'b11 : ((word_q >= DEPTH_W) ? 2'b01 : 2'b00);
        state_d  = RD_RSP;
      end
      RD_RSP: begin
        if (bus.iReadyRsp) begin
          if (beat_last) begin
            state_d = IDLE;
          end else begin
            beat_d  = beat_q + 2'd1;
            word_d  = word_q + ONE_W;
            state_d = RD_ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      word_q    <= '0;
      beat_q    <= '0;
      len_q     <= '0;
      status_q  <= '0;
      tag_q     <= '0;
      misal_q   <= 1'b0;
      last_rd_q <= 1'b1;
      data_q    <= '0;
      wr_cs_q   <= 1'b0;
      wr_addr_q <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      beat_q    <= beat_d;
      len_q     <= len_d;
      status_q  <= status_d;
      tag_q     <= tag_d;
      misal_q   <= misal_d;
      last_rd_q <= last_rd_d;
      data_q    <= data_d;
      wr_cs_q   <= wr_cs_d;
      wr_addr_q <= wr_addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
    end
  end

  // Ready is combinational from the request valids, so it must be masked by reset
  assign bus.oReadyWr   = !reset && (gnt_wr || (state_q == WR));
  assign bus.oReadyRd   = !reset && gnt_rd;
  assign bus.oValidRsp  = (state_q == RD_RSP);
  assign bus.oTagRsp    = tag_q;
  assign bus.oDataRsp   = data_q;
  assign bus.oStatusRsp = status_q;
  assign bus.oEoD       = (state_q == RD_RSP) && beat_last;
  assign bus.oMemCs     = wr_cs_q || ((state_q == RD_ISSUE) && beat_ok);
  assign bus.oMemWe     = wr_cs_q;
  assign bus.oMemAddr   = wr_cs_q ? wr_addr_q : word_q[AW-1:0];
  assign bus.oMemWdata  = wdata_q;
  assign bus.oMemBe     = be_q;
endmodule

// File: tb/tb_mem_access_responder.sv
// Directed bench for mem_access_responder with a behavioural SRAM and a write log.
module tb_mem_access_responder;
  logic clk = 1'b0;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   wcnt     = 0;
  int   rcnt     = 0;
  int   wbase, rbase;
  logic exp_rd;

  logic [31:0] mem     [1024];
  logic [9:0]  wl_addr [256];
  logic [31:0] wl_data [256];
  logic [3:0]  wl_be   [256];

  mem_access_responder_if #(.AW(10)) bus ();

  mem_access_responder #(.AW(10), .DEPTH(1024)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // SRAM model: byte-masked write, one-cycle registered read
  always @(posedge clk) begin
    if (bus.oMemCs && bus.oMemWe) begin
      for (int i = 0; i < 4; i++)
        if (bus.oMemBe[i]) mem[bus.oMemAddr][8*i +: 8] <= bus.oMemWdata[8*i +: 8];
      wl_addr[wcnt] <= bus.oMemAddr;
      wl_data[wcnt] <= bus.oMemWdata;
      wl_be[wcnt]   <= bus.oMemBe;
      wcnt          <= wcnt + 1;
    end
    if (bus.oMemCs && !bus.oMemWe) begin
      bus.iMemRdata <= mem[bus.oMemAddr];
      rcnt          <= rcnt + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hs_wr();
    int n = 0;
    #1;
    while (!bus.oReadyWr && n < 20) begin @(negedge clk); #1; n++; end
    chk("wr_handshake", bus.oReadyWr, 1);
    @(negedge clk);
  endtask

  task automatic wr_burst(input logic [31:0] addr, input logic [1:0] len, input logic [3:0] mask,
                          input int eod_beat, input logic [31:0] d0, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] d3);
    logic [31:0] d [4];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    for (int b = 0; b <= int'(len) && b <= eod_beat; b++) begin
      bus.iValidWr = 1'b1;
      bus.iAddrWr  = addr;
      bus.iLenWr   = len;
      bus.iMaskWr  = mask;
      bus.iDataWr  = d[b];
      bus.iEoD     = (b == eod_beat);
      hs_wr();
    end
    bus.iValidWr = 1'b0;
    bus.iEoD     = 1'b0;
  endtask

  task automatic rd_req(input logic [31:0] addr, input logic [1:0] len, input logic [3:0] tag);
    int n = 0;
    bus.iValidRd = 1'b1;
    bus.iAddrRd  = addr;
    bus.iLenRd   = len;
    bus.iTagRd   = tag;
    #1;
    while (!bus.oReadyRd && n < 20) begin @(negedge clk); #1; n++; end
    chk("rd_handshake", bus.oReadyRd, 1);
    @(negedge clk);
    bus.iValidRd = 1'b0;
  endtask

  task automatic rd_beat(input string tag, input logic [31:0] exp_data, input logic [1:0] exp_st,
                         input logic exp_eod, input logic [3:0] exp_tag, input int hold);
    int n = 0;
    while (!bus.oValidRsp && n < 10) begin @(negedge clk); n++; end
    chk({tag, "_valid"},  bus.oValidRsp,  1);
    chk({tag, "_data"},   bus.oDataRsp,   exp_data);
    chk({tag, "_status"}, bus.oStatusRsp, exp_st);
    chk({tag, "_eod"},    bus.oEoD,       exp_eod);
    chk({tag, "_tag"},    bus.oTagRsp,    exp_tag);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, bus.oValidRsp, 1);
      chk({tag, "_hold_data"},  bus.oDataRsp,  exp_data);
    end
    bus.iReadyRsp = 1'b1;
    @(negedge clk);
    bus.iReadyRsp = 1'b0;
    chk({tag, "_released"}, bus.oValidRsp, 0);
  endtask

  initial begin
    reset = 1'b1;
    bus.iValidRd = 1'b1; bus.iAddrRd = '0; bus.iTagRd = '0; bus.iIdRd = '0;
    bus.iLenRd = '0; bus.iQoSRd = '0; bus.iReadyRsp = 1'b0;
    bus.iValidWr = 1'b1; bus.iAddrWr = '0; bus.iTagWr = '0; bus.iIdWr = '0;
    bus.iLenWr = '0; bus.iQoSWr = '0; bus.iDataWr = '0; bus.iMaskWr = '0; bus.iEoD = 1'b0;

    // reset state, with both request valids high
    @(negedge clk);
    chk("rst_ready_rd", bus.oReadyRd, 0);
    chk("rst_ready_wr", bus.oReadyWr, 0);
    chk("rst_valid",    bus.oValidRsp, 0);
    chk("rst_memcs",    bus.oMemCs, 0);
    chk("rst_data",     bus.oDataRsp, 0);
    bus.iValidRd = 1'b0;
    bus.iValidWr = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // 1: four-beat write to words 4..7, then read back with tag 5
    wbase = wcnt;
    wr_burst(32'h10, 2'd3, 4'hF, 3, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
    @(negedge clk);
    chk("t1_wcount", wcnt - wbase, 4);
    for (int k = 0; k < 4; k++) begin
      chk("t1_waddr", wl_addr[wbase+k], 4 + k);
      chk("t1_wdata", wl_data[wbase+k], 32'hA0 + k);
    end
    chk("t1_wbe", wl_be[wbase], 4'hF);
    rd_req(32'h10, 2'd3, 4'h5);
    chk("t1_lat1_valid", bus.oValidRsp, 0);
    chk("t1_issue_cs",   bus.oMemCs, 1);
    chk("t1_issue_we",   bus.oMemWe, 0);
    chk("t1_issue_addr", bus.oMemAddr, 4);
    @(negedge clk);
    chk("t1_lat2_valid", bus.oValidRsp, 0);
    @(negedge clk);
    chk("t1_lat3_valid", bus.oValidRsp, 1);
    rd_beat("t1_b0", 32'hA0, 2'b00, 1'b0, 4'h5, 0);
    rd_beat("t1_b1", 32'hA1, 2'b00, 1'b0, 4'h5, 0);
    rd_beat("t1_b2", 32'hA2, 2'b00, 1'b0, 4'h5, 0);
    rd_beat("t1_b3", 32'hA3, 2'b00, 1'b1, 4'h5, 0);

    // 2: response held stable while iReadyRsp stays low
    rd_req(32'h10, 2'd1, 4'h2);
    rd_beat("t2_b0", 32'hA0, 2'b00, 1'b0, 4'h2, 5);
    rd_beat("t2_b1", 32'hA1, 2'b00, 1'b1, 4'h2, 0);

    // 3: iEoD on beat 1 of a four-beat write ends the burst early
    wbase = wcnt;
    wr_burst(32'h40, 2'd3, 4'hF, 1, 32'hB0, 32'hB1, 32'hB2, 32'hB3);
    #1;
    chk("t3_idle_ready_wr", bus.oReadyWr, 0);
    @(negedge clk);
    chk("t3_wcount", wcnt - wbase, 2);
    chk("t3_waddr0", wl_addr[wbase], 16);
    chk("t3_waddr1", wl_addr[wbase+1], 17);

    // byte enables: FF00FF00 from all-ones overwritten with mask 0101
    wr_burst(32'h20, 2'd0, 4'hF, 0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0);
    wr_burst(32'h20, 2'd0, 4'b0101, 0, 32'h0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    rd_req(32'h20, 2'd0, 4'h1);
    rd_beat("mask", 32'hFF00_FF00, 2'b00, 1'b1, 4'h1, 0);

    // 4: last word in range, next beat out of range; misaligned accesses
    wbase = wcnt;
    wr_burst(32'hFFC, 2'd1, 4'hF, 1, 32'hC0, 32'hC1, 32'h0, 32'h0);
    @(negedge clk);
    chk("t4_wcount", wcnt - wbase, 1);
    chk("t4_waddr",  wl_addr[wbase], 1023);
    rbase = rcnt;
    rd_req(32'hFFC, 2'd1, 4'h7);
    rd_beat("t4_b0", 32'hC0, 2'b00, 1'b0, 4'h7, 0);
    rd_beat("t4_b1", 32'h0,  2'b01, 1'b1, 4'h7, 0);
    chk("t4_rcount", rcnt - rbase, 1);
    wbase = wcnt;
    wr_burst(32'h2, 2'd0, 4'hF, 0, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("t4_misal_wcount", wcnt - wbase, 0);
    rbase = rcnt;
    rd_req(32'h12, 2'd1, 4'h3);
    rd_beat("t4_mis_b0", 32'h0, 2'b11, 1'b0, 4'h3, 0);
    rd_beat("t4_mis_b1", 32'h0, 2'b11, 1'b1, 4'h3, 0);
    chk("t4_misal_rcount", rcnt - rbase, 0);

    // 5: arbitration from a fresh reset
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    bus.iValidRd = 1'b1; bus.iAddrRd = 32'h10; bus.iLenRd = 2'd0; bus.iTagRd = 4'h9; bus.iQoSRd = 4'd2;
    bus.iValidWr = 1'b1; bus.iAddrWr = 32'h80; bus.iLenWr = 2'd0; bus.iDataWr = 32'hD0;
    bus.iMaskWr = 4'hF; bus.iEoD = 1'b1; bus.iQoSWr = 4'd9;
    #1;
    chk("t5_first_wr", bus.oReadyWr, 1);
    chk("t5_first_rd", bus.oReadyRd, 0);
    @(negedge clk);
    bus.iQoSRd = 4'd5;
    bus.iQoSWr = 4'd5;
    #1;
    chk("t5_tie_rd", bus.oReadyRd, 1);
    chk("t5_tie_wr", bus.oReadyWr, 0);
    @(negedge clk);
    bus.iValidRd = 1'b0;
    bus.iValidWr = 1'b0;
    rd_beat("t5_rd", 32'hA0, 2'b00, 1'b1, 4'h9, 0);
    bus.iQoSRd = 4'd9;
    bus.iQoSWr = 4'd2;
    bus.iValidRd = 1'b1;
    bus.iValidWr = 1'b1;
`ifdef MEM_RSP_QOS_ARB_EN
    exp_rd = 1'b1;
`else
    exp_rd = 1'b0;
`endif
    #1;
    chk("t5_third_rd", bus.oReadyRd, exp_rd);
    chk("t5_third_wr", bus.oReadyWr, !exp_rd);
    @(negedge clk);
    bus.iValidRd = 1'b0;
    bus.iValidWr = 1'b0;
    bus.iEoD     = 1'b0;
    if (exp_rd) rd_beat("t5_rd3", 32'hA0, 2'b00, 1'b1, 4'h9, 0);
    else        @(negedge clk);
    chk("t5_written", mem[32], 32'hD0);

    // 6: reset in the middle of a read burst
    rd_req(32'h10, 2'd3, 4'hE);
    @(negedge clk);
    @(negedge clk);
    chk("t6_pre_valid", bus.oValidRsp, 1);
    reset = 1'b1;
    #1;
    chk("t6_rst_valid",  bus.oValidRsp, 0);
    chk("t6_rst_data",   bus.oDataRsp, 0);
    chk("t6_rst_tag",    bus.oTagRsp, 0);
    chk("t6_rst_eod",    bus.oEoD, 0);
    chk("t6_rst_memcs",  bus.oMemCs, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t6_post_valid", bus.oValidRsp, 0);
      chk("t6_post_memcs", bus.oMemCs, 0);
    end
    rd_req(32'h14, 2'd0, 4'h4);
    rd_beat("t6_fresh", 32'hA1, 2'b00, 1'b1, 4'h4, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
